wb_queue: RTL and testbench
===========================

# wb_queue

Writeback queue sitting between the execute/memory stages and the 32x32 register file: it is the writer end of the register file's write port. It accepts results from two producers (MEM, ALU) with valid/ready handshakes and buffers them in a small in-order FIFO. It retires at most one entry per cycle onto the register-file write port, and forwards still-queued values to the operand-read side.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- DATA_W, 32: result width.
- ADDR_W, 5: register index width (32 registers).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- mem_valid  in  1  MEM result present.
- mem_ready  out  1  MEM result accepted this cycle if mem_valid.
- mem_rd  in  ADDR_W  MEM destination register.
- mem_data  in  DATA_W  MEM result.
- alu_valid / alu_ready / alu_rd / alu_data: same as MEM, ALU producer.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file destination address.
- rf_wdata  out  DATA_W  register-file write data.
- qa_addr, qb_addr  in  ADDR_W  operand lookup addresses.
- qa_hit, qb_hit  out  1  lookup matches a queued entry.
- qa_data, qb_data  out  DATA_W  forwarded value (0 when no hit).
- pending  out  $clog2(DEPTH+1)  current FIFO occupancy.
- idle  out  1  FIFO empty.

## Operation
- Entry = {rd, data}. Circular buffer, head/tail pointers, occupancy counter.
- Retire: whenever count != 0, rf_we=1 and rf_waddr/rf_wdata = head entry, driven combinationally from registered state; head pops at that clock edge. One retire per cycle, strict FIFO order.
- When empty: rf_we=0, rf_waddr=0, rf_wdata=0.
- free = DEPTH - count + (count != 0 ? 1 : 0), i.e. slots including the one freed by this cycle's retire.
- mem_ready = (free >= 1). alu_ready = (free >= 2) or (free >= 1 and !mem_valid). Neither ready depends on its own valid.
- Simultaneous accept: MEM enqueued first (older instruction), ALU second.
- rd == 0: handshake completes, entry is discarded (not enqueued, no write, no count change).
- Forwarding: per query port, search all valid entries including the head retiring this cycle. Return the youngest entry with rd == q_addr. qX_addr == 0 never hits. Values arriving on producer ports in the same cycle are not visible.
- idle = (count == 0). pending = count.
- reset: pointers and count cleared at the edge. While reset is high, rf_we=0, mem_ready=0, alu_ready=0, qa_hit=qb_hit=0 regardless of state. In-flight entries are dropped.

## Timing
- Enqueue at edge k; earliest retire write commits at edge k+1 (rf_we high during cycle k..k+1 with empty FIFO before k).
- Throughput: 1 retire/cycle sustained. Up to 2 accepts/cycle while space allows.
- Full (count == DEPTH): free = DEPTH-... = 1 via retire, so exactly one producer (MEM preferred) accepted per cycle.
- count never exceeds DEPTH. Pointers wrap modulo DEPTH.
- Reset outputs: rf_we=0, rf_waddr=0, rf_wdata=0, mem_ready=0, alu_ready=0, qa/qb_hit=0, qa/qb_data=0, pending=0, idle=1 (idle=1 from cycle after reset edge).

## Structure
- Package wb_pkg: DATA_W, ADDR_W defaults, typedef wb_entry_t {rd, data}, REG_ZERO constant.
- Sub-module wb_fifo: DEPTH-entry buffer with two push ports (ordered), one pop, exposes all entries + valid mask for the forwarding search.
- Top wb_queue: ready logic, rd==0 filter, two youngest-match forwarding muxes, reset gating.

## Test plan
- Single ALU result rd=5, data=0xDEADBEEF into empty queue -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF next cycle, idle=1 after.
- MEM rd=3/0x11 and ALU rd=3/0x22 same cycle -> writes retire 0x11 then 0x22; qa_addr=3 returns 0x22 while both queued, 0x22 after first retire.
- Fill to DEPTH=4 with no retire possible... drive 2/cycle for 3 cycles -> occupancy saturates at 4, alu_ready=0 while mem_valid=1, no entry lost, order preserved.
- rd=0 with data=0x55 -> ready=1, no rf_we, pending unchanged, qa_addr=0 hit=0.
- Reset asserted with 3 entries queued -> rf_we=0 and readies=0 during reset, pending=0, idle=1 afterward, no queued write reaches the register file.
- Random mixed traffic, 10k cycles -> register-file write sequence equals scoreboard model's in-order accepted stream. Forwarded data always equals the model's youngest pending value.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, entry type and constants for the writeback queue.
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// In-order entry buffer: two ordered push ports, one pop,
// entries exposed oldest-first for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push0,
  input  logic [ADDR_W-1:0] push0_rd,
  input  logic [DATA_W-1:0] push0_data,
  input  logic              push1,
  input  logic [ADDR_W-1:0] push1_rd,
  input  logic [DATA_W-1:0] push1_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] ent_rd [DEPTH],
  output logic [DATA_W-1:0] ent_data [DEPTH],
  output logic [DEPTH-1:0]  ent_valid
);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     slot1;
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // push1 lands behind push0 when both are taken
  assign slot1 = tail + PW'(push0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push0) + PW'(push1);
      count <= count + CW'(push0) + CW'(push1)
             - CW'(pop);
    end
    if (push0) begin
      rd_q[tail]   <= push0_rd;
      data_q[tail] <= push0_data;
    end
    if (push1) begin
      rd_q[slot1]   <= push1_rd;
      data_q[slot1] <= push1_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i]    = rd_q[head + PW'(i)];
      ent_data[i]  = data_q[head + PW'(i)];
      ent_valid[i] = (i < int'(count));
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: MEM/ALU producers in, one register-file
// write per cycle out, youngest-match forwarding to operand reads.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] qa_addr,
  input  logic [ADDR_W-1:0] qb_addr,
  output logic              qa_hit,
  output logic              qb_hit,
  output logic [DATA_W-1:0] qa_data,
  output logic [DATA_W-1:0] qb_data,
  output logic [CW-1:0]     pending,
  output logic              idle
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [CW-1:0]     count;
  logic [CW:0]       free;
  logic              busy;
  logic              push0;
  logic              push1;
  logic              pop;
  logic [ADDR_W-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;

  assign busy = (count != '0);

  // slots left after this cycle's retire
  assign free = (CW+1)'(DEPTH) - {1'b0, count}
              + {{CW{1'b0}}, busy};

  assign mem_ready = !reset && (free >= (CW+1)'(1));
  assign alu_ready = !reset
                  && ((free >= (CW+1)'(2)) || !mem_valid);

  // rd == 0 completes the handshake but is dropped
  assign push0 = mem_valid && mem_ready && (mem_rd != ZERO);
  assign push1 = alu_valid && alu_ready && (alu_rd != ZERO);
  assign pop   = !reset && busy;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (push0),
    .push0_rd   (mem_rd),
    .push0_data (mem_data),
    .push1      (push1),
    .push1_rd   (alu_rd),
    .push1_data (alu_data),
    .pop        (pop),
    .count      (count),
    .ent_rd     (ent_rd),
    .ent_data   (ent_data),
    .ent_valid  (ent_valid)
  );

  assign rf_we    = !reset && ent_valid[0];
  assign rf_waddr = rf_we ? ent_rd[0] : '0;
  assign rf_wdata = rf_we ? ent_data[0] : '0;

  // ascending scan: the last match is the youngest
  always_comb begin
    qa_hit  = 1'b0;
    qa_data = '0;
    qb_hit  = 1'b0;
    qb_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && ent_valid[i] && qa_addr != ZERO
          && ent_rd[i] == qa_addr) begin
        qa_hit  = 1'b1;
        qa_data = ent_data[i];
      end
      if (!reset && ent_valid[i] && qb_addr != ZERO
          && ent_rd[i] == qb_addr) begin
        qb_hit  = 1'b1;
        qb_data = ent_data[i];
      end
    end
  end

  assign pending = count;
  assign idle    = !busy;

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  qa_addr = '0;
  logic [4:0]  qb_addr = '0;
  logic        qa_hit;
  logic        qb_hit;
  logic [31:0] qa_data;
  logic [31:0] qb_data;
  logic [2:0]  pending;
  logic        idle;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;

  wb_entry_t q[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .qa_addr(qa_addr), .qb_addr(qb_addr),
    .qa_hit(qa_hit), .qb_hit(qb_hit),
    .qa_data(qa_data), .qb_data(qb_data),
    .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int free_slots(input int n);
    return DEPTH - n + ((n > 0) ? 1 : 0);
  endfunction

  function automatic void look(input logic [4:0] a,
                               output logic h,
                               output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (!reset && a != 5'd0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].rd == a) begin
          h = 1'b1;
          d = q[i].data;
          break;
        end
  endfunction

  // model: what the outputs must be this cycle
  always @(negedge clk) begin
    int n;
    int f;
    logic ha, hb;
    logic [31:0] da, db;
    if (started) begin
      n = q.size();
      f = free_slots(n);
      chk("rf_we", 32'(rf_we), 32'(!reset && n > 0));
      chk("rf_waddr", 32'(rf_waddr),
          (!reset && n > 0) ? 32'(q[0].rd) : 32'd0);
      chk("rf_wdata", rf_wdata,
          (!reset && n > 0) ? q[0].data : 32'd0);
      chk("mem_ready", 32'(mem_ready), 32'(!reset && f >= 1));
      chk("alu_ready", 32'(alu_ready),
          32'(!reset && (f >= 2 || !mem_valid)));
      chk("pending", 32'(pending), 32'(n));
      chk("idle", 32'(idle), 32'(n == 0));
      look(qa_addr, ha, da);
      look(qb_addr, hb, db);
      chk("qa_hit", 32'(qa_hit), 32'(ha));
      chk("qa_data", qa_data, da);
      chk("qb_hit", 32'(qb_hit), 32'(hb));
      chk("qb_data", qb_data, db);
    end
  end

  // model: state change at the edge
  always @(posedge clk) begin
    int f;
    bit mr, ar;
    if (reset) begin
      q.delete();
    end else begin
      f = free_slots(q.size());
      mr = (f >= 1);
      ar = (f >= 2) || !mem_valid;
      if (q.size() > 0) void'(q.pop_front());
      if (mem_valid && mr && mem_rd != 5'd0)
        q.push_back({mem_rd, mem_data});
      if (alu_valid && ar && alu_rd != 5'd0)
        q.push_back({alu_rd, alu_data});
    end
    started = 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr,
                       input logic [31:0] md, input logic av,
                       input logic [4:0] ar, input logic [31:0] ad);
    mem_valid = mv;
    mem_rd    = mr;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
  endtask

  task automatic quiet;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset state
    repeat (2) tick;
    @(negedge clk);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    tick;

    // single ALU result
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    tick;
    quiet();
    @(negedge clk);
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_waddr", 32'(rf_waddr), 32'd5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    tick;
    @(negedge clk);
    chk("t1_idle", 32'(idle), 32'd1);
    tick;

    // same-cycle MEM then ALU to same rd
    qa_addr = 5'd3;
    drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    @(negedge clk);
    chk("t2_nohit_same_cycle", 32'(qa_hit), 32'd0);
    tick;
    quiet();
    @(negedge clk);
    chk("t2_first_wdata", rf_wdata, 32'h11);
    chk("t2_fwd_young", qa_data, 32'h22);
    chk("t2_pending", 32'(pending), 32'd2);
    tick;
    @(negedge clk);
    chk("t2_second_wdata", rf_wdata, 32'h22);
    chk("t2_fwd_after", qa_data, 32'h22);
    repeat (3) tick;

    // fill to full, two producers per cycle
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(2*k+1), 32'((2*k+1) * 256),
            1, 5'(2*k+2), 32'((2*k+2) * 256));
      if (k == 3) begin
        @(negedge clk);
        chk("t3_full_pending", 32'(pending), 32'd4);
        chk("t3_alu_blocked", 32'(alu_ready), 32'd0);
        chk("t3_mem_ok", 32'(mem_ready), 32'd1);
      end
      tick;
    end
    quiet();
    @(negedge clk);
    chk("t3_head_order", 32'(rf_waddr), 32'd4);
    chk("t3_pending_sat", 32'(pending), 32'd4);
    repeat (6) tick;

    // rd == 0 discarded
    qa_addr = 5'd0;
    drive(1, 5'd0, 32'h55, 0, 0, 0);
    @(negedge clk);
    chk("t4_ready", 32'(mem_ready), 32'd1);
    chk("t4_qa0_hit", 32'(qa_hit), 32'd0);
    tick;
    quiet();
    @(negedge clk);
    chk("t4_no_we", 32'(rf_we), 32'd0);
    chk("t4_pending", 32'(pending), 32'd0);
    tick;

    // reset with three queued entries
    qa_addr = 5'd7;
    drive(1, 5'd7, 32'h70, 1, 5'd8, 32'h80);
    tick;
    drive(1, 5'd9, 32'h90, 1, 5'd10, 32'hA0);
    tick;
    quiet();
    reset = 1'b1;
    drive(1, 5'd11, 32'hB0, 1, 5'd12, 32'hC0);
    @(negedge clk);
    chk("t5_pending3", 32'(pending), 32'd3);
    chk("t5_we_rst", 32'(rf_we), 32'd0);
    chk("t5_mrdy_rst", 32'(mem_ready), 32'd0);
    chk("t5_ardy_rst", 32'(alu_ready), 32'd0);
    chk("t5_hit_rst", 32'(qa_hit), 32'd0);
    tick;
    reset = 1'b0;
    quiet();
    @(negedge clk);
    chk("t5_pending0", 32'(pending), 32'd0);
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_no_write", 32'(rf_we), 32'd0);
    tick;

    // random mixed traffic
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)),
            $urandom);
      qa_addr = 5'($urandom_range(0, 7));
      qb_addr = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 999) == 0);
      tick;
    end
    reset = 1'b0;
    quiet();
    repeat (6) tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
